// File: rtl/rmii_rx_framer.sv
// RMII 100 Mb/s receive framer: strips preamble/SFD, assembles bytes and reports length/status per frame.
// Define RMII_RX_FCS_CHECK_EN to also check the CRC-32 FCS residue at end of frame.
module rmii_rx_framer #(
    parameter int unsigned MIN_BYTES = 64,
    parameter int unsigned MAX_BYTES = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crs_dv,
    input  logic [1:0]  rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_err,
    output logic [10:0] rx_len
);
    localparam int unsigned LEN_W = 11;
    localparam logic [LEN_W-1:0] LEN_SAT = '1;
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, PREAMBLE, DATA, DROP} state_e;

    state_e           state_q;
    logic             d_dv_q;
    logic [1:0]       d_rxd_q;
    logic             seen01_q;
    logic [1:0]       dibit_cnt_q;
    logic [7:0]       shift_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             rx_sof_q;
    logic             rx_eof_q;
    logic             rx_err_q;
    logic [LEN_W-1:0] rx_len_q;

    // A delayed dibit stays qualified while CRS_DV toggles at end of carrier.
    logic       dib_valid_c;
    logic       eof_det_c;
    logic [7:0] byte_c;
    logic       byte_emit_c;
    logic       len_err_c;
    logic       fcs_bad_c;

    assign dib_valid_c = d_dv_q | crs_dv;
    assign eof_det_c   = ~d_dv_q & ~crs_dv;
    assign byte_c      = {d_rxd_q, shift_q[7:2]};
    assign byte_emit_c = (state_q == DATA) && dib_valid_c && (dibit_cnt_q == 2'd3)
                         && (byte_cnt_q < MAX_LEN);
    assign len_err_c   = (dibit_cnt_q != 2'd0) || (byte_cnt_q < MIN_LEN) || (byte_cnt_q > MAX_LEN);

`ifdef RMII_RX_FCS_CHECK_EN
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    logic [31:0] crc_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // Reflected register holds the bit-reversed form of the MSB-first residue.
    assign fcs_bad_c = (bitrev32(crc_q) != CRC_RESIDUE);

    always_ff @(posedge clk) begin
        if (rst || (state_q != DATA)) begin
            crc_q <= '1;
        end else if (byte_emit_c) begin
            crc_q <= crc_byte(crc_q, byte_c);
        end
    end
`else
    assign fcs_bad_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WAIT_IDLE;
            d_dv_q      <= 1'b0;
            d_rxd_q     <= 2'b00;
            seen01_q    <= 1'b0;
            dibit_cnt_q <= 2'd0;
            shift_q     <= 8'd0;
            byte_cnt_q  <= '0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_sof_q    <= 1'b0;
            rx_eof_q    <= 1'b0;
            rx_err_q    <= 1'b0;
            rx_len_q    <= '0;
        end else begin
            d_dv_q     <= crs_dv;
            d_rxd_q    <= rxd;
            rx_valid_q <= 1'b0;
            rx_sof_q   <= 1'b0;
            rx_eof_q   <= 1'b0;
            case (state_q)
                WAIT_IDLE: if (!crs_dv) state_q <= IDLE;
                IDLE: begin
                    if (dib_valid_c) begin
                        state_q  <= PREAMBLE;
                        seen01_q <= (d_rxd_q == 2'b01);
                    end
                end
                PREAMBLE: begin
                    if (eof_det_c) begin
                        state_q <= IDLE;
                    end else begin
                        case (d_rxd_q)
                            2'b00: ;
                            2'b01: seen01_q <= 1'b1;
                            2'b11: begin
                                if (seen01_q) begin
                                    state_q     <= DATA;
                                    dibit_cnt_q <= 2'd0;
                                    byte_cnt_q  <= '0;
                                end else begin
                                    state_q <= DROP;
                                end
                            end
                            default: state_q <= DROP;
                        endcase
                    end
                end
                DATA: begin
                    if (eof_det_c) begin
                        rx_eof_q <= 1'b1;
                        rx_len_q <= byte_cnt_q;
                        rx_err_q <= len_err_c | fcs_bad_c;
                        state_q  <= IDLE;
                    end else begin
                        shift_q     <= byte_c;
                        dibit_cnt_q <= dibit_cnt_q + 2'd1;
                        if (dibit_cnt_q == 2'd3) begin
                            if (byte_emit_c) begin
                                rx_valid_q <= 1'b1;
                                rx_data_q  <= byte_c;
                                rx_sof_q   <= (byte_cnt_q == '0);
                            end
                            if (byte_cnt_q != LEN_SAT) byte_cnt_q <= byte_cnt_q + 11'd1;
                        end
                    end
                end
                DROP: if (eof_det_c) state_q <= IDLE;
                default: state_q <= WAIT_IDLE;
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_sof   = rx_sof_q;
    assign rx_eof   = rx_eof_q;
    assign rx_err   = rx_err_q;
    assign rx_len   = rx_len_q;
endmodule
